// File: rtl/cordic_pkg.sv
// Shared fixed-point constants, atan table, FSM state type and helpers for
// the CORDIC polar/Cartesian converters.
package cordic_pkg;

  localparam int DATA_W   = 16;  // external Q3.12 width
  localparam int FRAC_W   = 12;  // fractional bits
  localparam int INT_W    = 18;  // internal x/y width (Q5.12)
  localparam int Z_W      = 17;  // internal angle accumulator width
  localparam int K_W      = 14;  // gain constant width (unsigned Q0.14)
  localparam int PROD_W   = K_W + DATA_W;
  localparam int MAX_ITER = 13;
  localparam int CNT_W    = 4;

  localparam logic signed [Z_W-1:0] PI_Q12      = 17'sd12868;
  localparam logic signed [Z_W-1:0] HALF_PI_Q12 = 17'sd6434;

  // 1/1.64676 in unsigned Q0.14
  localparam logic [K_W-1:0] K_GAIN_DEF = 14'd9949;

  // atan(2^-i) in Q3.12, round-to-nearest; entry 0 sits in the LSBs
  localparam logic [MAX_ITER-1:0][Z_W-1:0] ATAN_TAB = {
    17'd1,   17'd2,   17'd4,    17'd8,    17'd16,   17'd32, 17'd64,
    17'd128, 17'd256, 17'd509,  17'd1003, 17'd1899, 17'd3217
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCALE = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Clamp an internal Q5.12 value onto the external Q3.12 range
  function automatic logic signed [DATA_W-1:0] sat_q12(
    input logic signed [INT_W-1:0] v
  );
    logic signed [DATA_W-1:0] res;
    if (v[INT_W-1:DATA_W-1] == '0 || v[INT_W-1:DATA_W-1] == '1)
      res = v[DATA_W-1:0];
    else if (v[INT_W-1])
      res = 16'sh8000;
    else
      res = 16'sh7fff;
    return res;
  endfunction

endpackage

// File: rtl/cordicpol2cart_if.sv
// Block-level ap_* handshake plus polar operands and Cartesian results.
interface cordicpol2cart_if;
  import cordic_pkg::*;

  logic                     ap_start;
  logic                     ap_done;
  logic                     ap_idle;
  logic                     ap_ready;
  logic signed [DATA_W-1:0] r;
  logic signed [DATA_W-1:0] theta;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] y;

  modport master (
    output ap_start, r, theta,
    input  ap_done, ap_idle, ap_ready, x, y
  );

  modport slave (
    input  ap_start, r, theta,
    output ap_done, ap_idle, ap_ready, x, y
  );

endinterface

// File: rtl/cordicpol2cart_gain_mul.sv
// Combinational 14-bit unsigned x 16-bit signed gain multiply. Both operands
// are widened to the product width so the 30-bit result is exact.
module cordicpol2cart_gain_mul
  import cordic_pkg::*;
(
  input  logic        [K_W-1:0]    k,
  input  logic signed [DATA_W-1:0] a,
  output logic signed [PROD_W-1:0] p
);

  logic signed [PROD_W-1:0] k_ext;
  logic signed [PROD_W-1:0] a_ext;

  assign k_ext = $signed({{DATA_W{1'b0}}, k});
  assign a_ext = $signed({{K_W{a[DATA_W-1]}}, a});
  assign p     = k_ext * a_ext;

endmodule

// File: rtl/cordicpol2cart.sv
// Iterative rotation-mode CORDIC: polar (r, theta) in Q3.12 to Cartesian
// (x, y) in Q3.12, one micro-rotation per clock, ap_* block protocol.
module cordicpol2cart
  import cordic_pkg::*;
#(
  parameter int             NUM_ITER = 12,
  parameter logic [K_W-1:0] K_GAIN   = K_GAIN_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  cordicpol2cart_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_I = CNT_W'(NUM_ITER - 1);

  state_t                   state;
  logic [CNT_W-1:0]         iter;
  logic signed [DATA_W-1:0] r_q;
  logic signed [DATA_W-1:0] th_q;
  logic signed [INT_W-1:0]  xq;
  logic signed [INT_W-1:0]  yq;
  logic signed [Z_W-1:0]    zq;
  logic signed [DATA_W-1:0] x_out;
  logic signed [DATA_W-1:0] y_out;
  logic                     done_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [INT_W-1:0]  rk;
  logic signed [Z_W-1:0]    th_z;
  logic signed [INT_W-1:0]  sx;
  logic signed [INT_W-1:0]  sy;
  logic signed [Z_W-1:0]    atan_i;

  cordicpol2cart_gain_mul u_gain_mul (
    .k (K_GAIN),
    .a (r_q),
    .p (prod)
  );

  // Gain-compensated magnitude (truncating >>14), angle and shifted operands
  assign rk     = INT_W'(prod >>> K_W);
  assign th_z   = $signed({th_q[DATA_W-1], th_q});
  assign sx     = xq >>> iter;
  assign sy     = yq >>> iter;
  assign atan_i = $signed(ATAN_TAB[iter]);

  assign bus.ap_idle  = (state == S_IDLE);
  assign bus.ap_ready = (state == S_IDLE) && bus.ap_start;
  assign bus.ap_done  = done_q;
  assign bus.x        = x_out;
  assign bus.y        = y_out;

  // Control FSM and x/y/z datapath; reset discards any result in flight
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state  <= S_IDLE;
      iter   <= '0;
      r_q    <= '0;
      th_q   <= '0;
      xq     <= '0;
      yq     <= '0;
      zq     <= '0;
      x_out  <= '0;
      y_out  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.ap_start) begin
            r_q   <= bus.r;
            th_q  <= bus.theta;
            state <= S_SCALE;
          end
        end
        S_SCALE: begin
          // Fold angles beyond +-pi/2 into range by negating x0
          if (th_z > HALF_PI_Q12) begin
            xq <= -rk;
            zq <= th_z - PI_Q12;
          end else if (th_z < -HALF_PI_Q12) begin
            xq <= -rk;
            zq <= th_z + PI_Q12;
          end else begin
            xq <= rk;
            zq <= th_z;
          end
          yq    <= '0;
          iter  <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          if (!zq[Z_W-1]) begin
            xq <= xq - sy;
            yq <= yq + sx;
            zq <= zq - atan_i;
          end else begin
            xq <= xq + sy;
            yq <= yq - sx;
            zq <= zq + atan_i;
          end
          iter <= iter + 1'b1;
          if (iter == LAST_I) state <= S_DONE;
        end
        S_DONE: begin
          x_out  <= sat_q12(xq);
          y_out  <= sat_q12(yq);
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordicpol2cart.sv
// Directed bench for cordicpol2cart: reference vectors, latency, reset and
// handshake behaviour.
module tb_cordicpol2cart;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  always #5 ap_clk = ~ap_clk;

  cordicpol2cart_if bus();

  cordicpol2cart #(.NUM_ITER(12), .K_GAIN(14'd9949)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
    n_cmp++;
    if (got < exp - tol || got > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (+-%0d)", tag, got, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Present a request; returns after the edge that samples it
  task automatic start_op(input int rr, input int th);
    bus.r        = 16'(rr);
    bus.theta    = 16'(th);
    bus.ap_start = 1'b1;
    #1;
    chk("ready_in_idle", int'(bus.ap_ready), 1);
    chk("idle_at_start", int'(bus.ap_idle), 1);
    tick();
  endtask

  // Count edges until ap_done is seen; bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.ap_done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  int vr [8] = '{4096, 4096,  4096,   8192, 32767, 4096,  4096,  0};
  int vt [8] = '{0,    6434, -12868,  3217, 0,     12868, -6434, 1000};
  int vx [8] = '{4096, 0,    -4096,   5793, 32767, -4096, 0,     0};
  int vy [8] = '{0,    4096,  0,      5793, 0,     0,     -4096, 0};

  initial begin
    int lat;
    int hx, hy;
    int cnt;

    bus.ap_start = 1'b0;
    bus.r        = '0;
    bus.theta    = '0;
    repeat (3) tick();
    chk("rst_idle",  int'(bus.ap_idle), 1);
    chk("rst_done",  int'(bus.ap_done), 0);
    chk("rst_ready", int'(bus.ap_ready), 0);
    chk("rst_x",     int'(bus.x), 0);
    chk("rst_y",     int'(bus.y), 0);
    ap_rst_n = 1'b1;
    tick();

    // Reference vectors
    for (int k = 0; k < 8; k++) begin
      start_op(vr[k], vt[k]);
      bus.ap_start = 1'b0;
      chk("busy_not_idle", int'(bus.ap_idle), 0);
      wait_done(lat);
      chk($sformatf("lat%0d", k), lat, 14);
      chk($sformatf("x%0d", k), int'(bus.x), vx[k], 8);
      chk($sformatf("y%0d", k), int'(bus.y), vy[k], 8);
      hx = int'(bus.x);
      hy = int'(bus.y);
      tick();
      chk("done_pulse", int'(bus.ap_done), 0);
      chk("x_held", int'(bus.x), hx);
      chk("y_held", int'(bus.y), hy);
    end

    // ap_start during ITER is ignored and not queued
    start_op(4096, 3217);
    bus.ap_start = 1'b0;
    repeat (4) tick();
    bus.ap_start = 1'b1;
    #1;
    chk("ready_mid_iter", int'(bus.ap_ready), 0);
    tick();
    bus.ap_start = 1'b0;
    wait_done(lat);
    chk("lat_mid_pulse", lat, 14 - 5);
    chk("x_mid", int'(bus.x), 2896, 8);
    chk("y_mid", int'(bus.y), 2896, 8);
    cnt = 0;
    repeat (20) begin
      tick();
      if (!bus.ap_idle || bus.ap_done) cnt++;
    end
    chk("no_queued_op", cnt, 0);

    // Held ap_start: results NUM_ITER+3 cycles apart
    bus.r        = 16'sd4096;
    bus.theta    = 16'sd0;
    bus.ap_start = 1'b1;
    tick();
    wait_done(lat);
    chk("b2b_first_lat", lat, 14);
    tick();
    wait_done(lat);
    chk("b2b_interval", lat + 1, 15);
    bus.ap_start = 1'b0;
    chk("b2b_x", int'(bus.x), 4096, 8);
    chk("b2b_y", int'(bus.y), 0, 8);
    tick();
    tick();
    chk("b2b_stopped", int'(bus.ap_idle), 1);

    // Reset in ITER cycle 5 discards the result
    start_op(4096, 6434);
    bus.ap_start = 1'b0;
    repeat (5) tick();
    ap_rst_n = 1'b0;
    tick();
    chk("midrst_idle", int'(bus.ap_idle), 1);
    chk("midrst_x",    int'(bus.x), 0);
    chk("midrst_y",    int'(bus.y), 0);
    chk("midrst_done", int'(bus.ap_done), 0);
    ap_rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      tick();
      if (bus.ap_done) cnt++;
    end
    chk("midrst_no_done", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordicpol2cart.md
# cordicpol2cart

Iterative rotation-mode CORDIC that converts a polar input (magnitude r, angle theta) to Cartesian (x, y). It is the inverse companion of cordiccart2pol in the same CORDIC project. It uses the same fixed-point formats, so a pol2cart → cart2pol round trip can be checked bit-accurately in the testbench. Control follows the ap_start/ap_done block-level protocol, so it can replace the HLS-generated top.

## Interface
- NUM_ITER, 12, CORDIC micro-rotations performed; legal range 1..13.
- K_GAIN, 9949, gain-compensation constant 1/1.64676, unsigned Q0.14.
- ap_clk  in  1  clock; everything is registered on the rising edge.
- ap_rst_n  in  1  synchronous, active-low reset.
- ap_start  in  1  request; sampled only while ap_idle=1.
- ap_done  out  1  one-cycle pulse; x and y are valid from this cycle.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  one-cycle pulse in the cycle r and theta are captured.
- r  in  16  magnitude, signed Q3.12; legal range 0..32767.
- theta  in  16  angle in radians, signed Q3.12; legal range -12868..12868 (±π).
- x  out  16  r·cos(theta), signed Q3.12; held until the next ap_done.
- y  out  16  r·sin(theta), signed Q3.12; held until the next ap_done.

## Operation
- FSM has four states: IDLE, SCALE, ITER, DONE.
- IDLE:
  - If ap_start=1: capture r and theta, pulse ap_ready, go to SCALE.
  - Otherwise stay in IDLE.
- SCALE:
  - Compute rk = (K_GAIN × r) >> 14. Operands are 14-bit unsigned × 16-bit signed, giving a 30-bit product; the shift truncates.
  - Quadrant fold:
    - theta > 6434 (π/2): x0 = −rk, z0 = theta − 12868.
    - theta < −6434: x0 = −rk, z0 = theta + 12868.
    - Otherwise: x0 = rk, z0 = theta.
  - y0 = 0. Clear the iteration counter i. Go to ITER.
- ITER (one micro-rotation per cycle, i = 0..NUM_ITER−1):
  - d = +1 when z ≥ 0, else −1.
  - x ← x − d·(y >>> i)
  - y ← y + d·(x >>> i)
  - z ← z − d·atan[i]
  - Shifts are arithmetic. After i = NUM_ITER−1, go to DONE.
- DONE:
  - Saturate internal x and y to 16-bit signed (clamp to −32768..32767), register them to the outputs, pulse ap_done, return to IDLE.
- Internal datapath: x and y are 18-bit signed (Q5.12); z is 17-bit signed.
- atan table, Q3.12, round-to-nearest, i = 0..12: 3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2, 1.
- ap_start outside IDLE is ignored; it is not queued.
- Out-of-range r or theta is not checked; the result is undefined but the FSM must still complete.

## Timing
- Reset (ap_rst_n=0 at a clock edge):
  - FSM goes to IDLE; ap_idle=1.
  - ap_done=0, ap_ready=0, x=0, y=0; internal registers cleared.
  - Reset wins over any state, including mid-ITER. The pending result is discarded and no ap_done is issued.
- Latency: ap_start sampled in IDLE at edge N → ap_done high in cycle N + NUM_ITER + 2. Default 14 cycles.
- ap_ready and ap_idle are both high in the same cycle (IDLE with ap_start=1).
- Back-to-back: ap_start held high through DONE is accepted in the next IDLE cycle. Throughput is one result per NUM_ITER + 3 cycles.
- Outputs change only in the ap_done cycle.

## Structure
- Shared package cordic_pkg holds:
  - fixed-point widths (DATA_W=16, FRAC_W=12, INT_W=18);
  - PI_Q12=12868 and HALF_PI_Q12=6434;
  - the atan table constant;
  - the state enum;
  - the default K_GAIN.
- One sub-module, cordicpol2cart_gain_mul: a purely combinational 14-bit unsigned × 16-bit signed → 30-bit signed multiplier, instantiated once for the SCALE step.
- Top level contains the FSM, the iteration counter and the x/y/z datapath.

## Test plan
All checks allow ±8 LSB unless noted. Use NUM_ITER=12.
- r=4096, theta=0 → x≈4096, y≈0; ap_done exactly 14 cycles after ap_start; ap_ready pulses in the start cycle.
- r=4096, theta=6434 → x≈0, y≈4096.
- r=4096, theta=−12868 (fold path) → x≈−4096, y≈0.
- r=8192, theta=3217 → x≈5793, y≈5793.
- r=32767, theta=0 → x=32767 (saturated or within tolerance), y≈0.
- Reset and protocol:
  - Assert ap_rst_n=0 in ITER cycle 5 → next cycle ap_idle=1, x=y=0, no ap_done.
  - ap_start pulsed mid-ITER is ignored.
  - ap_start held high gives results 15 cycles apart.
